// File: rtl/master_traffic_gen.sv
// master_traffic_gen: LFSR-driven request generator with outstanding-read throttling
module master_traffic_gen #(
  parameter int          MNUM      = 0,
  parameter int          TRANS_NUM = 64,
  parameter int          MAX_OUTST = 8,
  parameter logic [31:0] SEED      = 32'h1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  output logic        master_req,
  output logic [31:0] master_addr,
  output logic        master_cmd,
  output logic [31:0] master_wdata,
  input  logic        master_ack,
  input  logic [31:0] master_rdata,
  input  logic        master_resp,
  input  logic        rdreq_fifo_full,
  output logic [7:0]  outst_o,
  output logic [15:0] issued_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o
);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
  localparam logic [15:0] TN = 16'(TRANS_NUM);
  localparam logic [7:0]  MO = 8'(MAX_OUTST);
  localparam logic [3:0]  MN = 4'(MNUM);
  state_t      state, state_nx;
  logic [31:0] lfsr, lfsr_nx, addr_nx;
  logic [7:0]  outst_nx;
  logic [15:0] issued_nx;
  logic        acc, rd_acc, start_ok, launch, underflow;
  logic        unused_rdata;
  assign unused_rdata = ^master_rdata;
  assign busy_o = state == ISSUE || state == DRAIN;
  assign done_o = state == DONE;
  // Next-state, counter updates and launch decision; the next request is built from the post-accept LFSR
  always_comb begin
    acc       = master_req & master_ack;
    rd_acc    = acc & ~master_cmd;
    start_ok  = start_i & (state == IDLE || state == DONE);
    lfsr_nx   = acc ? ({1'b0, lfsr[31:1]} ^ (lfsr[0] ? 32'h8020_0003 : 32'h0)) : lfsr;
    addr_nx   = {MN, lfsr_nx[25:0], 2'b00};
    underflow = master_resp & ~rd_acc & (outst_o == 8'd0);
    outst_nx  = (rd_acc & ~master_resp) ? outst_o + 8'd1 :
                (master_resp & ~rd_acc & outst_o != 8'd0) ? outst_o - 8'd1 : outst_o;
    issued_nx = start_ok ? 16'd0 : (acc && issued_o != TN) ? issued_o + 16'd1 : issued_o;
    state_nx  = start_ok ? ISSUE :
                (state == ISSUE && issued_nx == TN) ? DRAIN :
                (state == DRAIN && outst_o == 8'd0) ? DONE : state;
    launch    = state == ISSUE && (!master_req || acc) && issued_nx < TN &&
                outst_nx < MO && !rdreq_fifo_full;
  end
  // State, counters, LFSR and the held request registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= IDLE;
      master_req   <= 1'b0;
      master_addr  <= '0;
      master_cmd   <= 1'b0;
      master_wdata <= '0;
      lfsr         <= SEED;
      outst_o      <= '0;
      issued_o     <= '0;
      err_o        <= 1'b0;
    end else begin
      state    <= state_nx;
      lfsr     <= lfsr_nx;
      outst_o  <= outst_nx;
      issued_o <= issued_nx;
      err_o    <= err_o | underflow;
      if (launch) begin
        master_req   <= 1'b1;
        master_addr  <= addr_nx;
        master_wdata <= addr_nx;
        master_cmd   <= lfsr_nx[27];
      end else if (acc) begin
        master_req <= 1'b0;
      end
    end
  end
endmodule
